// File: rtl/w_block_scheduler.sv
// ---------------------------------------------------------------------------
// w_block_scheduler
//
// Sequences one weight-matrix pass through the row-to-block converter and
// dispatches each BLOCK_SIZE x CHUNK_SIZE slice to the MAC core owning its
// column group. The converter cannot be stalled, so its output lands in a
// small skid FIFO; slices that arrive while the FIFO is full are dropped and
// flagged with a sticky overflow error.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   start           one-cycle pulse starting a pass (honoured in IDLE only)
//   busy            high while the pass is running or draining
//   done            one-cycle pulse at pass completion
//   err_overflow    sticky: a slice was dropped because the FIFO was full
//   conv_en         converter enable, high only while running
//   conv_valid      converter slice strobe
//   conv_data       converter slice data
//   core_valid      one-hot valid towards the core targeted by the FIFO head
//   core_ready      per-core ready
//   core_data       FIFO head data, shared by all cores
//   core_row_blk    row-block index of the FIFO head
//   core_col_grp    column-group index of the FIFO head
// ---------------------------------------------------------------------------
module w_block_scheduler #(
    parameter int WIDTH      = 16,
    parameter int ROW        = 256,
    parameter int COL        = 64,
    parameter int BLOCK_SIZE = 2,
    parameter int CHUNK_SIZE = 4,
    parameter int NUM_CORES  = 4,
    parameter int FIFO_DEPTH = 4,
    localparam int SLICE_W   = WIDTH * BLOCK_SIZE * (CHUNK_SIZE / 2),
    localparam int RB        = ROW / BLOCK_SIZE,
    localparam int CG        = COL / BLOCK_SIZE,
    localparam int RB_W      = (RB > 1) ? $clog2(RB) : 1,
    localparam int CG_W      = (CG > 1) ? $clog2(CG) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 err_overflow,
    output logic                 conv_en,
    input  logic                 conv_valid,
    input  logic [SLICE_W-1:0]   conv_data,
    output logic [NUM_CORES-1:0] core_valid,
    input  logic [NUM_CORES-1:0] core_ready,
    output logic [SLICE_W-1:0]   core_data,
    output logic [RB_W-1:0]      core_row_blk,
    output logic [CG_W-1:0]      core_col_grp
);

    localparam int TOTAL = RB * CG;
    localparam int WC_W  = $clog2(TOTAL + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    // A FIFO entry carries its tag so dispatch never has to recompute it.
    typedef struct packed {
        logic [SLICE_W-1:0] data;
        logic [RB_W-1:0]    row_blk;
        logic [CG_W-1:0]    col_grp;
    } entry_t;

    state_t             state;
    state_t             state_next;

    logic [WC_W-1:0]    wc;
    logic [RB_W-1:0]    row_cnt;
    logic [CG_W-1:0]    col_cnt;

    entry_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    entry_t             head;
    entry_t             last;

    logic               fifo_empty;
    logic               fifo_full;
    logic               accept;
    logic               push;
    logic               pop;
    logic               overflow;
    logic               last_slice;
    logic               start_pass;

    // -----------------------------------------------------------------------
    // FIFO status and handshakes
    // -----------------------------------------------------------------------
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign head       = mem[rd_ptr];

    // Every slice seen while running is counted, whether or not it fits.
    assign accept     = (state == S_RUN) && conv_valid;
    assign pop        = |(core_valid & core_ready);
    assign push       = accept && (!fifo_full || pop);
    assign overflow   = accept && fifo_full && !pop;
    assign last_slice = accept && (wc == WC_W'(TOTAL - 1));
    assign start_pass = (state == S_IDLE) && start;

    // Head-of-line dispatch: only the core owning the head's column group
    // sees valid, so ready from any other core cannot pop the entry.
    always_comb begin
        core_valid = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            core_valid[i] = !fifo_empty &&
                            ((32'(head.col_grp) % NUM_CORES) == unsigned'(i));
        end
    end

    // While empty, the outputs hold the most recently popped entry.
    assign core_data    = fifo_empty ? last.data    : head.data;
    assign core_row_blk = fifo_empty ? last.row_blk : head.row_blk;
    assign core_col_grp = fifo_empty ? last.col_grp : head.col_grp;

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block gets a default first; a path that
    // left one unassigned would infer a latch.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        conv_en    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_next = S_RUN;
            end
            S_RUN: begin
                busy    = 1'b1;
                conv_en = 1'b1;
                if (last_slice) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (fifo_empty || (count == CNT_W'(1) && pop)) state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Slice counter and tag generation (row block fastest, then column group)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wc      <= '0;
            row_cnt <= '0;
            col_cnt <= '0;
        end else if (start_pass) begin
            wc      <= '0;
            row_cnt <= '0;
            col_cnt <= '0;
        end else if (accept) begin
            wc <= wc + WC_W'(1);
            if (row_cnt == RB_W'(RB - 1)) begin
                row_cnt <= '0;
                col_cnt <= col_cnt + CG_W'(1);
            end else begin
                row_cnt <= row_cnt + RB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             err_overflow <= 1'b0;
        else if (start_pass) err_overflow <= 1'b0;
        else if (overflow)   err_overflow <= 1'b1;
    end

    // -----------------------------------------------------------------------
    // Skid FIFO
    // -----------------------------------------------------------------------
    // NOTE: the storage array has no reset; the occupancy count guards every
    // read, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{data: conv_data, row_blk: row_cnt, col_grp: col_cnt};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                last   <= head;
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_w_block_scheduler.sv
// ---------------------------------------------------------------------------
// tb_w_block_scheduler
//
// Directed bench for w_block_scheduler with ROW=4, COL=4, BLOCK_SIZE=2,
// CHUNK_SIZE=4, NUM_CORES=2 (RB=2, CG=2, TOTAL=4, 64-bit slices). Instance
// dut uses a 4-entry FIFO; dut_b uses a 2-entry FIFO for the overflow case.
// Inputs change 1 ns after the rising edge and outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_w_block_scheduler;

    localparam int SW = 64;

    logic          clk = 1'b0;
    logic          rst;

    logic          start, busy, done, err_overflow, conv_en, conv_valid;
    logic [SW-1:0] conv_data, core_data;
    logic [1:0]    core_valid, core_ready;
    logic [0:0]    core_row_blk, core_col_grp;

    logic          start_b, busy_b, done_b, err_overflow_b, conv_en_b, conv_valid_b;
    logic [SW-1:0] conv_data_b, core_data_b;
    logic [1:0]    core_valid_b, core_ready_b;
    logic [0:0]    core_row_blk_b, core_col_grp_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    w_block_scheduler #(
        .WIDTH(16), .ROW(4), .COL(4), .BLOCK_SIZE(2), .CHUNK_SIZE(4),
        .NUM_CORES(2), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .err_overflow(err_overflow), .conv_en(conv_en),
        .conv_valid(conv_valid), .conv_data(conv_data),
        .core_valid(core_valid), .core_ready(core_ready),
        .core_data(core_data), .core_row_blk(core_row_blk),
        .core_col_grp(core_col_grp)
    );

    w_block_scheduler #(
        .WIDTH(16), .ROW(4), .COL(4), .BLOCK_SIZE(2), .CHUNK_SIZE(4),
        .NUM_CORES(2), .FIFO_DEPTH(2)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .err_overflow(err_overflow_b), .conv_en(conv_en_b),
        .conv_valid(conv_valid_b), .conv_data(conv_data_b),
        .core_valid(core_valid_b), .core_ready(core_ready_b),
        .core_data(core_data_b), .core_row_blk(core_row_blk_b),
        .core_col_grp(core_col_grp_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Head of dut: data, tag and one-hot valid in one go.
    task automatic check_head(input string tag, input logic [63:0] data,
                              input int row, input int col, input logic [1:0] valid);
        check({tag, "_data"}, core_data, data);
        check({tag, "_row"}, 64'(core_row_blk), 64'(row));
        check({tag, "_col"}, 64'(core_col_grp), 64'(col));
        check({tag, "_valid"}, 64'(core_valid), 64'(valid));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0; conv_valid = 1'b0; conv_data = '0; core_ready = 2'b00;
        start_b = 1'b0; conv_valid_b = 1'b0; conv_data_b = '0; core_ready_b = 2'b00;
        step(); step();

        // ---- reset state ----
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err_overflow), 64'd0);
        check("rst_conv_en", 64'(conv_en), 64'd0);
        check_head("rst", 64'h0, 0, 0, 2'b00);
        rst = 1'b0;
        step();

        // ---- nominal pass: one slice per cycle, all cores ready ----
        core_ready = 2'b11;
        start = 1'b1;
        step();
        start = 1'b0;
        check("nom_busy", 64'(busy), 64'd1);
        check("nom_conv_en", 64'(conv_en), 64'd1);
        for (int i = 0; i < 4; i++) begin
            conv_valid = 1'b1;
            conv_data  = 64'hA0 + 64'(i);
            step();
            check_head($sformatf("nom_%0d", i), 64'hA0 + 64'(i), i % 2, i / 2,
                       (i < 2) ? 2'b01 : 2'b10);
        end
        conv_valid = 1'b0;
        check("nom_drain_busy", 64'(busy), 64'd1);
        check("nom_drain_conv_en", 64'(conv_en), 64'd0);
        step();
        check("nom_done", 64'(done), 64'd1);
        check("nom_done_valid", 64'(core_valid), 64'd0);
        check("nom_hold_data", core_data, 64'hA3);
        check("nom_err", 64'(err_overflow), 64'd0);
        step();
        check("nom_done_pulse", 64'(done), 64'd0);
        check("nom_idle_busy", 64'(busy), 64'd0);

        // ---- backpressure: ready low for 6 cycles, FIFO fills to 4 ----
        core_ready = 2'b00;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            conv_valid = 1'b1;
            conv_data  = 64'hA0 + 64'(i);
            step();
            check_head($sformatf("bp_fill_%0d", i), 64'hA0, 0, 0, 2'b01);
        end
        conv_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check_head($sformatf("bp_stall_%0d", i), 64'hA0, 0, 0, 2'b01);
            check("bp_busy", 64'(busy), 64'd1);
        end
        check("bp_err", 64'(err_overflow), 64'd0);
        core_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            check_head($sformatf("bp_drain_%0d", k), 64'hA0 + 64'(k), k % 2, k / 2,
                       (k < 2) ? 2'b01 : 2'b10);
            step();
        end
        check("bp_done", 64'(done), 64'd1);
        step();
        check("bp_done_pulse", 64'(done), 64'd0);

        // ---- head-of-line: only the non-target core is ready ----
        core_ready = 2'b10;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            conv_valid = 1'b1;
            conv_data  = 64'hA0 + 64'(i);
            step();
            check_head($sformatf("hol_%0d", i), 64'hA0, 0, 0, 2'b01);
        end
        conv_valid = 1'b0;
        step();
        check_head("hol_stuck", 64'hA0, 0, 0, 2'b01);
        core_ready = 2'b01;
        step();
        check_head("hol_pop0", 64'hA1, 1, 0, 2'b01);
        step();
        check_head("hol_pop1", 64'hA2, 0, 1, 2'b10);
        step();
        check_head("hol_stuck1", 64'hA2, 0, 1, 2'b10);
        core_ready = 2'b11;
        step();
        check_head("hol_pop2", 64'hA3, 1, 1, 2'b10);
        step();
        check("hol_done", 64'(done), 64'd1);
        step();

        // ---- reset mid-pass ----
        core_ready = 2'b00;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            conv_valid = 1'b1;
            conv_data  = 64'hC0 + 64'(i);
            step();
        end
        conv_valid = 1'b0;
        check("mid_valid_pre", 64'(core_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check_head("mid_rst", 64'h0, 0, 0, 2'b00);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("mid_no_done_%0d", i), 64'(done), 64'd0);
        end

        // ---- conv_valid in IDLE is ignored ----
        for (int i = 0; i < 3; i++) begin
            conv_valid = 1'b1;
            conv_data  = 64'hEE;
            step();
            check($sformatf("idle_valid_%0d", i), 64'(core_valid), 64'd0);
            check($sformatf("idle_busy_%0d", i), 64'(busy), 64'd0);
        end
        conv_valid = 1'b0;

        // ---- clean pass, start pulsed during RUN must be ignored ----
        core_ready = 2'b11;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            conv_valid = 1'b1;
            conv_data  = 64'hB0 + 64'(i);
            start      = (i == 1);
            step();
            check_head($sformatf("clean_%0d", i), 64'hB0 + 64'(i), i % 2, i / 2,
                       (i < 2) ? 2'b01 : 2'b10);
        end
        start = 1'b0;
        conv_valid = 1'b0;
        step();
        check("clean_done", 64'(done), 64'd1);
        step();

        // ---- overflow on the 2-entry instance ----
        core_ready_b = 2'b00;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            conv_valid_b = 1'b1;
            conv_data_b  = 64'hA0 + 64'(i);
            step();
            check($sformatf("ovf_err_%0d", i), 64'(err_overflow_b), (i >= 2) ? 64'd1 : 64'd0);
        end
        conv_valid_b = 1'b0;
        check("ovf_busy", 64'(busy_b), 64'd1);
        check("ovf_head0", core_data_b, 64'hA0);
        check("ovf_valid0", 64'(core_valid_b), 64'd1);
        core_ready_b = 2'b11;
        step();
        check("ovf_head1", core_data_b, 64'hA1);
        check("ovf_row1", 64'(core_row_blk_b), 64'd1);
        check("ovf_col1", 64'(core_col_grp_b), 64'd0);
        step();
        check("ovf_done", 64'(done_b), 64'd1);
        check("ovf_err_held", 64'(err_overflow_b), 64'd1);
        step();
        check("ovf_idle_busy", 64'(busy_b), 64'd0);
        check("ovf_err_idle", 64'(err_overflow_b), 64'd1);
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        check("ovf_err_cleared", 64'(err_overflow_b), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/w_block_scheduler.md
Name: w_block_scheduler

Overview:
- Sequences one weight-matrix pass through the row-to-block weight converter and dispatches its BLOCK_SIZE x CHUNK_SIZE slices to NUM_CORES multi-MAC cores.
- Asserts the converter enable and absorbs converter output in a small skid FIFO, because the converter has no backpressure.
- Routes each slice to the core that owns its column group, using a per-core valid/ready handshake.
- Reports pass completion and overflow errors to the top-level matmul controller.

Parameters:
- WIDTH, 16, element width in bits
- ROW, 256, weight matrix rows
- COL, 64, weight matrix columns
- BLOCK_SIZE, 2, rows per slice and columns per column group
- CHUNK_SIZE, 4, elements per slice; must be even
- NUM_CORES, 4, number of MAC cores (power of two, >=1)
- FIFO_DEPTH, 4, skid FIFO entries (power of two, >=2)
- Derived: SLICE_W = WIDTH*BLOCK_SIZE*(CHUNK_SIZE/2); RB = ROW/BLOCK_SIZE; CG = COL/BLOCK_SIZE; TOTAL = RB*CG

Ports:
- clk  in  1  clock, all logic on the rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that begins a pass; honoured only in IDLE
- busy  out  1  high in RUN or DRAIN
- done  out  1  one-cycle pulse when the pass completes
- err_overflow  out  1  sticky; a slice arrived while the FIFO was full
- conv_en  out  1  enable to the converter, high only in RUN
- conv_valid  in  1  converter output_ready
- conv_data  in  SLICE_W  converter slice data
- core_valid  out  NUM_CORES  one-hot valid to the target core
- core_ready  in  NUM_CORES  per-core ready
- core_data  out  SLICE_W  shared data bus to all cores (FIFO head)
- core_row_blk  out  clog2(RB)  row-block index of the head slice
- core_col_grp  out  clog2(CG)  column-group index of the head slice

Behaviour:
- Reset (async, rst=1): state=IDLE; all counters and FIFO pointers cleared. Outputs forced: busy=0, done=0, err_overflow=0, conv_en=0, core_valid=0, core_data=0, core_row_blk=0, core_col_grp=0. Reset mid-pass abandons the pass with no done pulse.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start. On the same edge, err_overflow and the slice counter are cleared.
  - RUN -> DRAIN on the edge where the TOTAL-th slice is accepted.
  - DRAIN -> DONE when the FIFO is empty, including the edge that pops the last entry.
  - DONE -> IDLE unconditionally after 1 cycle; done=1 only while in DONE.
  - start in any state other than IDLE is ignored.
- Slice tagging:
  - A write counter wc (0..TOTAL-1) increments per accepted slice.
  - Tag is row_blk = wc mod RB and col_grp = wc / RB. This matches the converter order: row block fastest, then column group.
  - The tag is stored alongside the data in the FIFO.
- Target core = col_grp mod NUM_CORES, decoded from the head entry tag.
- FIFO push: conv_valid=1 in RUN, and FIFO not full or a pop happens on the same edge.
- FIFO overflow: conv_valid=1 in RUN with FIFO full and no pop:
  - slice dropped, wc still increments;
  - err_overflow set, and held until rst or the next accepted start.
- conv_valid outside RUN is ignored: no push, no count.
- Dispatch:
  - core_valid[target]=1 whenever the FIFO is non-empty; all other bits are 0.
  - core_data, core_row_blk and core_col_grp show the head entry; they are held at the last value when the FIFO is empty.
  - Pop on core_valid[target] & core_ready[target]. Ready on non-target cores is ignored.
  - Head-of-line blocking is intended: order is preserved.
- Latency: a slice pushed at edge t is presented at core_valid after edge t when the FIFO was empty (1 cycle). At most one pop per cycle.
- Simultaneous push and pop: occupancy unchanged; legal when full.
- Width rules: all indices are unsigned; wc is wide enough for TOTAL; pointer wrap is modulo FIFO_DEPTH.

Test Plan (ROW=4, COL=4, NUM_CORES=2, FIFO_DEPTH=4, so RB=2, CG=2, TOTAL=4):
- Nominal pass:
  - Stimulus: start; 4 slices 0xA0..0xA3 on consecutive cycles; core_ready=2'b11.
  - Expected: tags (0,0),(1,0),(0,1),(1,1); core_valid = 01,01,10,10, each 1 cycle after its push; done 1 pulse; err_overflow=0.
- Backpressure:
  - Stimulus: core_ready=2'b00 for 6 cycles, then 2'b11.
  - Expected: FIFO holds 4 entries; head stays 0xA0 on core_valid=01 while ready is low; err_overflow=0; all 4 slices delivered in order, then done.
- Overflow:
  - Stimulus: FIFO_DEPTH=2, core_ready=0, 4 slices pushed.
  - Expected: only 0xA0 and 0xA1 kept; err_overflow=1 and held; done still fires after the 2 entries drain.
- Head-of-line:
  - Stimulus: core_ready=2'b10 while head targets core 0.
  - Expected: no pop and core_valid=01 stable until core_ready[0]=1.
- Reset / start guard:
  - Stimulus: rst=1 after 2 slices.
  - Expected: busy=0 and core_valid=0 immediately, no done pulse; a new start runs a clean pass with tags restarting at (0,0).
  - Stimulus: start during RUN. Expected: ignored.
- Ignored input:
  - Stimulus: conv_valid pulses while in IDLE.
  - Expected: no core_valid; wc stays 0.
